// File: rtl/gemm_operand_fetch.sv
// GEMM operand fetch: walks i/j/k over A and B SRAMs and streams operand pairs through a 2-entry FIFO.
// Optional GEMM_FETCH_PERF_EN adds a saturating stall_cycles counter output.
module gemm_operand_fetch #(
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_valid,
    input  logic [7:0]            M_dimmension,
    input  logic [7:0]            K_dimmension,
    input  logic [7:0]            N_dimmension,
    output logic                  busy,
    output logic                  read_enable_A,
    output logic [ADDR_WIDTH-1:0] address_A,
    input  logic [DATA_WIDTH-1:0] data_out_A,
    output logic                  read_enable_B,
    output logic [ADDR_WIDTH-1:0] address_B,
    input  logic [DATA_WIDTH-1:0] data_out_B,
    output logic                  op_valid,
    input  logic                  op_ready,
    output logic [DATA_WIDTH-1:0] op_a,
    output logic [DATA_WIDTH-1:0] op_b,
    output logic [7:0]            op_row,
    output logic [7:0]            op_col,
    output logic                  op_last,
`ifdef GEMM_FETCH_PERF_EN
    output logic [31:0]           stall_cycles,
`endif
    output logic                  done
);

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;
    state_t state, state_nxt;

    logic [7:0] m_dim, k_dim, n_dim;
    logic [7:0] i_cnt, j_cnt, k_cnt;
    logic       rd_pend, pend_last;
    logic [7:0] pend_row, pend_col;

    logic [DATA_WIDTH-1:0] fifo_a [2];
    logic [DATA_WIDTH-1:0] fifo_b [2];
    logic [7:0]            fifo_row [2];
    logic [7:0]            fifo_col [2];
    logic                  fifo_last [2];
    logic                  wr_ptr, rd_ptr;
    logic [1:0]            count;

    logic start, zero_dim, issue, last_issue, xfer, bypass, pop_fifo, push, final_xfer;

    assign start      = (state == IDLE) && in_valid;
    assign zero_dim   = (M_dimmension == 8'd0) || (K_dimmension == 8'd0) || (N_dimmension == 8'd0);
    // Reads in flight count against FIFO space so returning data always has a slot.
    assign issue      = (state == ISSUE) && ((count + {1'b0, rd_pend}) < 2'd2);
    assign last_issue = issue && (i_cnt == m_dim - 8'd1) && (j_cnt == n_dim - 8'd1)
                        && (k_cnt == k_dim - 8'd1);

    assign op_valid   = (count != 2'd0) || rd_pend;
    assign xfer       = op_valid && op_ready;
    // With an empty FIFO the returning read is presented directly; it is only stored if not taken.
    assign bypass     = xfer && (count == 2'd0);
    assign pop_fifo   = xfer && (count != 2'd0);
    assign push       = rd_pend && !bypass;
    assign final_xfer = xfer && op_last && (op_row == m_dim - 8'd1) && (op_col == n_dim - 8'd1);

    always_comb begin
        op_a    = '0;
        op_b    = '0;
        op_row  = '0;
        op_col  = '0;
        op_last = 1'b0;
        if (count != 2'd0) begin
            op_a    = fifo_a[rd_ptr];
            op_b    = fifo_b[rd_ptr];
            op_row  = fifo_row[rd_ptr];
            op_col  = fifo_col[rd_ptr];
            op_last = fifo_last[rd_ptr];
        end else if (rd_pend) begin
            op_a    = data_out_A;
            op_b    = data_out_B;
            op_row  = pend_row;
            op_col  = pend_col;
            op_last = pend_last;
        end
    end

    always_comb begin
        state_nxt     = state;
        busy          = (state != IDLE);
        done          = (state == DONE);
        read_enable_A = issue;
        read_enable_B = issue;
        address_A     = '0;
        address_B     = '0;
        if (state == ISSUE) begin
            address_A = ADDR_WIDTH'(i_cnt) * ADDR_WIDTH'(k_dim) + ADDR_WIDTH'(k_cnt);
            address_B = ADDR_WIDTH'(k_cnt) * ADDR_WIDTH'(n_dim) + ADDR_WIDTH'(j_cnt);
        end
        case (state)
            IDLE:    if (start) state_nxt = zero_dim ? DONE : ISSUE;
            ISSUE:   if (last_issue) state_nxt = DRAIN;
            DRAIN:   if (final_xfer) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            m_dim     <= '0;
            k_dim     <= '0;
            n_dim     <= '0;
            i_cnt     <= '0;
            j_cnt     <= '0;
            k_cnt     <= '0;
            rd_pend   <= 1'b0;
            pend_row  <= '0;
            pend_col  <= '0;
            pend_last <= 1'b0;
        end else begin
            state   <= state_nxt;
            rd_pend <= issue;
            if (start) begin
                m_dim <= M_dimmension;
                k_dim <= K_dimmension;
                n_dim <= N_dimmension;
                i_cnt <= '0;
                j_cnt <= '0;
                k_cnt <= '0;
            end else if (issue) begin
                if (k_cnt == k_dim - 8'd1) begin
                    k_cnt <= '0;
                    if (j_cnt == n_dim - 8'd1) begin
                        j_cnt <= '0;
                        i_cnt <= i_cnt + 8'd1;
                    end else begin
                        j_cnt <= j_cnt + 8'd1;
                    end
                end else begin
                    k_cnt <= k_cnt + 8'd1;
                end
            end
            if (issue) begin
                pend_row  <= i_cnt;
                pend_col  <= j_cnt;
                pend_last <= (k_cnt == k_dim - 8'd1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count  <= '0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            for (int e = 0; e < 2; e++) begin
                fifo_a[e]    <= '0;
                fifo_b[e]    <= '0;
                fifo_row[e]  <= '0;
                fifo_col[e]  <= '0;
                fifo_last[e] <= 1'b0;
            end
        end else begin
            if (push) begin
                fifo_a[wr_ptr]    <= data_out_A;
                fifo_b[wr_ptr]    <= data_out_B;
                fifo_row[wr_ptr]  <= pend_row;
                fifo_col[wr_ptr]  <= pend_col;
                fifo_last[wr_ptr] <= pend_last;
                wr_ptr            <= ~wr_ptr;
            end
            if (pop_fifo) rd_ptr <= ~rd_ptr;
            case ({push, pop_fifo})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

`ifdef GEMM_FETCH_PERF_EN
    always_ff @(posedge clk) begin
        if (reset || start) begin
            stall_cycles <= '0;
        end else if (op_valid && !op_ready && (stall_cycles != 32'hFFFF_FFFF)) begin
            stall_cycles <= stall_cycles + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_gemm_operand_fetch.sv
// Self-checking bench for gemm_operand_fetch: SRAM model, loop-order scoreboard, directed corner cases.
// Define GEMM_FETCH_PERF_EN to also exercise the stall counter.
module tb_gemm_operand_fetch;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        in_valid = 1'b0;
    logic [7:0]  M_dimmension = '0, K_dimmension = '0, N_dimmension = '0;
    logic        busy, read_enable_A, read_enable_B, op_valid, op_last, done;
    logic        op_ready = 1'b1;
    logic [15:0] address_A, address_B;
    logic [31:0] data_out_A = '0, data_out_B = '0;
    logic [31:0] op_a, op_b;
    logic [7:0]  op_row, op_col;
`ifdef GEMM_FETCH_PERF_EN
    logic [31:0] stall_cycles;
`endif

    gemm_operand_fetch #(.ADDR_WIDTH(16), .DATA_WIDTH(32)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid),
        .M_dimmension(M_dimmension), .K_dimmension(K_dimmension), .N_dimmension(N_dimmension),
        .busy(busy),
        .read_enable_A(read_enable_A), .address_A(address_A), .data_out_A(data_out_A),
        .read_enable_B(read_enable_B), .address_B(address_B), .data_out_B(data_out_B),
        .op_valid(op_valid), .op_ready(op_ready), .op_a(op_a), .op_b(op_b),
        .op_row(op_row), .op_col(op_col), .op_last(op_last),
`ifdef GEMM_FETCH_PERF_EN
        .stall_cycles(stall_cycles),
`endif
        .done(done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] a, b;
        logic [7:0]  r, c;
        logic        l;
    } pair_t;

    typedef struct {
        int m, k, n;
        bit rnd_ready;
        int exp_pairs;
    } vec_t;

    int total = 0, bad = 0;
    int cyc = 0;
    logic [31:0] salt_a = 32'h1234_5678, salt_b = 32'h8765_4321;
    pair_t exp_q[$];
    logic [15:0] addr_a_log[$], addr_b_log[$];
    logic        last_log[$];
    int pairs, reads, done_cnt, busy_cyc, done_cyc, xfer_first, xfer_last;
    int n_iss = 0, n_xfer = 0;
    bit rnd_ready = 0;
    bit prev_stall = 0;
    pair_t prev_p;

    function automatic logic [31:0] mem_a(input logic [15:0] ad);
        return salt_a ^ ({16'h0, ad} * 32'h9E37_79B1);
    endfunction
    function automatic logic [31:0] mem_b(input logic [15:0] ad);
        return salt_b ^ ({16'h0, ad} * 32'h85EB_CA6B);
    endfunction

    always @(posedge clk) begin
        cyc <= cyc + 1;
        data_out_A <= read_enable_A ? mem_a(address_A) : $urandom;
        data_out_B <= read_enable_B ? mem_b(address_B) : $urandom;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: scoreboard of transfers, stability while stalled, read pairing and occupancy bound.
    always @(negedge clk) begin
        if (reset) begin
            exp_q.delete();
            n_iss = 0;
            n_xfer = 0;
            prev_stall = 0;
        end else begin
            if (read_enable_A || read_enable_B) begin
                chk("re_pair", read_enable_B, read_enable_A);
                chk("re_busy", busy, 1);
                chk("outstanding_lt2", (n_iss - n_xfer) < 2, 1);
                addr_a_log.push_back(address_A);
                addr_b_log.push_back(address_B);
                n_iss++;
                reads++;
            end
            if (prev_stall) begin
                chk("hold_valid", op_valid, 1);
                chk("hold_a", op_a, prev_p.a);
                chk("hold_b", op_b, prev_p.b);
                chk("hold_row", op_row, prev_p.r);
                chk("hold_col", op_col, prev_p.c);
                chk("hold_last", op_last, prev_p.l);
            end
            if (op_valid && op_ready) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL extra_pair: got unexpected pair row=%0d col=%0d, expected none", op_row, op_col);
                end else begin
                    pair_t e;
                    e = exp_q.pop_front();
                    chk("pair_a", op_a, e.a);
                    chk("pair_b", op_b, e.b);
                    chk("pair_row", op_row, e.r);
                    chk("pair_col", op_col, e.c);
                    chk("pair_last", op_last, e.l);
                end
                if (pairs == 0) xfer_first = cyc;
                xfer_last = cyc;
                last_log.push_back(op_last);
                n_xfer++;
                pairs++;
            end
            prev_stall = op_valid && !op_ready;
            prev_p.a = op_a; prev_p.b = op_b; prev_p.r = op_row; prev_p.c = op_col; prev_p.l = op_last;
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
            end
            if (busy) busy_cyc++;
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rnd_ready) op_ready = ($urandom_range(0, 3) != 0);
        end
    end

    task automatic clear_stats();
        pairs = 0; reads = 0; done_cnt = 0; busy_cyc = 0; done_cyc = 0;
        xfer_first = 0; xfer_last = 0;
        addr_a_log.delete(); addr_b_log.delete(); last_log.delete();
    endtask

    // Expected stream straight from the loop nest and row-major addressing.
    task automatic start_job(input int m, input int k, input int n);
        pair_t p;
        salt_a = $urandom;
        salt_b = $urandom;
        if (m > 0 && k > 0 && n > 0)
            for (int i = 0; i < m; i++)
                for (int j = 0; j < n; j++)
                    for (int kk = 0; kk < k; kk++) begin
                        p.a = mem_a(16'(i * k + kk));
                        p.b = mem_b(16'(kk * n + j));
                        p.r = 8'(i);
                        p.c = 8'(j);
                        p.l = (kk == k - 1);
                        exp_q.push_back(p);
                    end
        @(posedge clk);
        #1;
        in_valid = 1'b1;
        M_dimmension = 8'(m);
        K_dimmension = 8'(k);
        N_dimmension = 8'(n);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        M_dimmension = 8'($urandom);
        K_dimmension = 8'($urandom);
        N_dimmension = 8'($urandom);
    endtask

    task automatic wait_done(input int budget);
        int t = 0;
        while (done_cnt == 0 && t < budget) begin
            @(posedge clk);
            t++;
        end
        chk("done_seen", done_cnt != 0, 1);
        repeat (2) @(posedge clk);
        #1;
    endtask

    vec_t vecs[8];

    initial begin
        vecs[0] = '{2, 2, 2, 0, 8};
        vecs[1] = '{1, 3, 1, 1, 3};
        vecs[2] = '{3, 1, 2, 1, 6};
        vecs[3] = '{1, 1, 1, 0, 1};
        vecs[4] = '{0, 3, 3, 0, 0};
        vecs[5] = '{4, 4, 4, 1, 64};
        vecs[6] = '{5, 2, 3, 1, 30};
        vecs[7] = '{3, 3, 0, 0, 0};
        clear_stats();

        // reset values
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_valid", op_valid, 0);
        chk("rst_done", done, 0);
        chk("rst_re", {read_enable_A, read_enable_B}, 0);
        chk("rst_addr", {address_A, address_B}, 0);
        chk("rst_op", {op_a, op_b, op_row, op_col, op_last}, 0);
        @(posedge clk);
        #1;
        reset = 1'b0;

        // 2x2x2 streaming: latency, address order, op_last positions, done timing
        begin
            logic [15:0] ea[8], eb[8];
            logic        el[8];
            ea = '{0, 1, 0, 1, 2, 3, 2, 3};
            eb = '{0, 2, 1, 3, 0, 2, 1, 3};
            el = '{0, 1, 0, 1, 0, 1, 0, 1};
            op_ready = 1'b1;
            clear_stats();
            start_job(2, 2, 2);
            @(negedge clk);
            chk("lat_re", read_enable_A, 1);
            chk("lat_valid_early", op_valid, 0);
            @(negedge clk);
            chk("lat_valid", op_valid, 1);
            wait_done(100);
            chk("s36_pairs", pairs, 8);
            chk("s36_nread", addr_a_log.size(), 8);
            for (int q = 0; q < 8 && q < addr_a_log.size(); q++) begin
                chk("s36_addr_a", addr_a_log[q], ea[q]);
                chk("s36_addr_b", addr_b_log[q], eb[q]);
            end
            for (int q = 0; q < 8 && q < last_log.size(); q++) chk("s36_last", last_log[q], el[q]);
            chk("s36_back2back", xfer_last - xfer_first, 7);
            chk("s36_done_lat", done_cyc - xfer_last, 1);
            chk("s36_done_cnt", done_cnt, 1);
        end

        // stall with a 1x3x1 job
        clear_stats();
        op_ready = 1'b0;
        start_job(1, 3, 1);
        begin
            int t = 0;
            while (!op_valid && t < 20) begin @(negedge clk); t++; end
            chk("s37_valid_seen", op_valid, 1);
        end
        repeat (5) @(posedge clk);
        #1;
        chk("s37_reads_le2", reads <= 2, 1);
        chk("s37_no_xfer", pairs, 0);
        op_ready = 1'b1;
        wait_done(100);
        chk("s37_pairs", pairs, 3);
        chk("s37_q_empty", exp_q.size(), 0);

        // zero K
        clear_stats();
        start_job(4, 0, 4);
        begin
            int sc;
            sc = cyc - 1;
            wait_done(20);
            chk("s38_reads", reads, 0);
            chk("s38_busy_cyc", busy_cyc, 1);
            chk("s38_done_lat", done_cyc - sc, 1);
        end

        // reset mid-job then 1x1x1
        clear_stats();
        start_job(4, 4, 4);
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        chk("s39_busy", busy, 0);
        chk("s39_valid", op_valid, 0);
        chk("s39_re", read_enable_A, 0);
        repeat (5) @(negedge clk);
        chk("s39_no_done", done_cnt, 0);
        chk("s39_valid_idle", op_valid, 0);
        clear_stats();
        start_job(1, 1, 1);
        wait_done(30);
        chk("s39_pairs", pairs, 1);
        chk("s39_reads", reads, 1);
        if (addr_a_log.size() > 0) begin
            chk("s39_addr_a", addr_a_log[0], 0);
            chk("s39_addr_b", addr_b_log[0], 0);
        end

        // in_valid mid-job ignored
        clear_stats();
        start_job(2, 2, 2);
        repeat (2) @(posedge clk);
        #1;
        in_valid = 1'b1;
        M_dimmension = 8'd7; K_dimmension = 8'd7; N_dimmension = 8'd7;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        wait_done(100);
        chk("s40_pairs", pairs, 8);
        chk("s40_done_cnt", done_cnt, 1);
        chk("s40_q_empty", exp_q.size(), 0);

        // table-driven jobs
        foreach (vecs[v]) begin
            clear_stats();
            rnd_ready = vecs[v].rnd_ready;
            op_ready = 1'b1;
            start_job(vecs[v].m, vecs[v].k, vecs[v].n);
            wait_done(vecs[v].exp_pairs * 10 + 40);
            rnd_ready = 0;
            op_ready = 1'b1;
            chk("vec_pairs", pairs, vecs[v].exp_pairs);
            chk("vec_reads", reads, vecs[v].exp_pairs);
            chk("vec_done_cnt", done_cnt, 1);
            chk("vec_q_empty", exp_q.size(), 0);
        end

        // random jobs, including wide addresses
        for (int r = 0; r < 8; r++) begin
            int m, k, n;
            m = $urandom_range(1, 5);
            k = $urandom_range(1, 5);
            n = $urandom_range(1, 5);
            if (r == 6) begin m = 3; k = 200; n = 1; end
            if (r == 7) begin m = 1; k = 3; n = 200; end
            clear_stats();
            rnd_ready = 1;
            start_job(m, k, n);
            wait_done(m * k * n * 10 + 40);
            rnd_ready = 0;
            op_ready = 1'b1;
            chk("rnd_pairs", pairs, m * k * n);
            chk("rnd_done_cnt", done_cnt, 1);
            chk("rnd_q_empty", exp_q.size(), 0);
        end

`ifdef GEMM_FETCH_PERF_EN
        clear_stats();
        op_ready = 1'b0;
        start_job(1, 1, 1);
        begin
            int t = 0;
            while (!op_valid && t < 20) begin @(negedge clk); t++; end
            chk("perf_valid_seen", op_valid, 1);
        end
        repeat (3) @(posedge clk);
        #1;
        op_ready = 1'b1;
        wait_done(30);
        chk("perf_stall_cycles", stall_cycles, 3);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got no finish, expected finish before time limit");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/gemm_operand_fetch.md
GEMM_OPERAND_FETCH -- requirements
Module: gemm_operand_fetch

Interface
REQ-001 Parameter ADDR_WIDTH, default 16: SRAM address width for A and B.
REQ-002 Parameter DATA_WIDTH, default 32: operand word width.
REQ-003 clk  input  1  sole clock; all logic on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 in_valid  input  1  start request, sampled only in IDLE.
REQ-006 M_dimmension, K_dimmension, N_dimmension  input  8 each  matrix dimensions, latched on start.
REQ-007 busy  output  1  job in progress.
REQ-008 read_enable_A  output  1  A SRAM read strobe.
REQ-009 address_A  output  ADDR_WIDTH  A read address.
REQ-010 data_out_A  input  DATA_WIDTH  A read data, valid the cycle after read_enable_A.
REQ-011 read_enable_B, address_B, data_out_B: same as REQ-008..010, for the B SRAM.
REQ-012 op_valid  output  1  operand pair available.
REQ-013 op_ready  input  1  downstream MAC array accepts the pair.
REQ-014 op_a, op_b  output  DATA_WIDTH each  operand pair.
REQ-015 op_row, op_col  output  8 each  output element index (i, j) of the pair.
REQ-016 op_last  output  1  pair is the final k for element (i, j).
REQ-017 done  output  1  one-cycle job-complete pulse.

Function
REQ-018 The FSM SHALL have states IDLE, ISSUE, DRAIN, DONE.
REQ-019 IDLE: in_valid=1 SHALL latch the dims, clear i/j/k, and go to ISSUE; go to DONE instead if any dim is 0, issuing no reads.
REQ-020 Loop order SHALL be i in 0..M-1 (outer), j in 0..N-1, k in 0..K-1 (inner).
REQ-021 address_A SHALL be i*K+k and address_B SHALL be k*N+j (row-major), computed at full ADDR_WIDTH without truncation for dims up to 255.
REQ-022 A and B reads SHALL always issue in the same cycle for the same (i, j, k).
REQ-023 Reads SHALL land in a 2-entry FIFO together with {i, j, last}; a read SHALL issue only if FIFO occupancy plus in-flight reads is below 2, so no data is ever dropped.
REQ-024 With op_ready held high, the block SHALL sustain one pair per cycle; the first op_valid SHALL occur 2 cycles after in_valid is accepted.
REQ-025 While op_valid=1 and op_ready=0, op_a, op_b, op_row, op_col and op_last SHALL stay stable.
REQ-026 A transfer SHALL occur when op_valid and op_ready are both 1; a FIFO push and pop in the same cycle SHALL leave occupancy unchanged.
REQ-027 After the last read issues, the FSM SHALL go to DRAIN; when the final pair (op_last, i=M-1, j=N-1) transfers, it SHALL go to DONE.
REQ-028 DONE SHALL assert done for exactly one cycle, then return to IDLE.
REQ-029 busy SHALL be 1 in ISSUE, DRAIN and DONE, and 0 in IDLE.
REQ-030 in_valid outside IDLE SHALL be ignored, and the latched dims SHALL not change.
REQ-031 read_enable_A and read_enable_B SHALL be 0 outside ISSUE.

Reset
REQ-032 reset=1 SHALL force IDLE and clear FIFO, counters and in-flight tracking, and drive busy, done, op_valid, read_enable_A and read_enable_B to 0, and all addresses and op_* data/index outputs to 0.
REQ-033 Reset mid-job SHALL abort the job without a done pulse; the in-flight read data returning on the next cycle SHALL be discarded.

Configuration
REQ-034 With GEMM_FETCH_PERF_EN defined, the block SHALL add output stall_cycles[31:0], counting cycles with op_valid=1 and op_ready=0, cleared on reset and on job start, saturating at 0xFFFFFFFF.
REQ-035 Without GEMM_FETCH_PERF_EN, neither the port nor the counter SHALL exist; all other behaviour SHALL be identical.

Verification
REQ-036 M=K=N=2, op_ready=1 -> 8 pairs on consecutive cycles; A addrs 0,1,0,1,2,3,2,3; B addrs 0,2,1,3,0,2,1,3; op_last on pairs 2,4,6,8; done 1 cycle after pair 8.
REQ-037 M=1, K=3, N=1, op_ready low for 5 cycles after first op_valid -> at most 2 reads issue; pair 1 held stable; all 3 pairs delivered in order after release.
REQ-038 K=0 with M=N=4 -> no read strobes; busy high 1 cycle; done pulses 1 cycle after start.
REQ-039 Reset asserted in cycle 4 of a 4x4x4 job -> next cycle busy=0, op_valid=0; a new 1x1x1 job then yields exactly one pair, with addresses 0 and 0.
REQ-040 in_valid pulsed mid-job with dims 7,7,7 -> ignored; the original 2x2x2 job completes with 8 pairs.
REQ-041 GEMM_FETCH_PERF_EN defined, op_ready low for 3 cycles while op_valid=1 -> stall_cycles=3 at done.
